// File: rtl/mealy_pattern_sequencer.sv
// Streams a latched word LSB-first into an external Mealy detector; done pulses in cycle len+1.
// start is taken only when ready (IDLE), never queued. Optional first-hit outputs: MEALY_SEQ_FIRSTHIT_EN.
module mealy_pattern_sequencer #(
  parameter int WORD_W = 16,
  parameter int LEN_W  = 5,
  parameter int CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] word,
  input  logic [LEN_W-1:0]  len,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic              det_i,
  input  logic [1:0]        det_o,
  output logic [CNT_W-1:0]  cnt_111,
  output logic [CNT_W-1:0]  cnt_001
`ifdef MEALY_SEQ_FIRSTHIT_EN
  ,
  output logic [LEN_W-1:0]  first_111_idx,
  output logic [LEN_W-1:0]  first_001_idx,
  output logic              first_111_vld,
  output logic              first_001_vld
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_111_q, cnt_111_d;
  logic [CNT_W-1:0]  cnt_001_q, cnt_001_d;
  logic [LEN_W-1:0]  len_clamp;
  logic              count_en;

  assign len_clamp = (len > LEN_W'(WORD_W)) ? LEN_W'(WORD_W) : len;
  // The detector keeps stale history for its first two bits, so those results are discarded.
  assign count_en  = (state_q == ST_RUN) && (idx_q >= LEN_W'(2));

`ifdef MEALY_SEQ_FIRSTHIT_EN
  logic [LEN_W-1:0] f111_idx_q, f111_idx_d;
  logic [LEN_W-1:0] f001_idx_q, f001_idx_d;
  logic             f111_vld_q, f111_vld_d;
  logic             f001_vld_q, f001_vld_d;

  always_comb begin
    f111_idx_d = f111_idx_q;
    f001_idx_d = f001_idx_q;
    f111_vld_d = f111_vld_q;
    f001_vld_d = f001_vld_q;
    if (state_q == ST_IDLE && start) begin
      f111_idx_d = '0;
      f001_idx_d = '0;
      f111_vld_d = 1'b0;
      f001_vld_d = 1'b0;
    end else if (count_en) begin
      if (det_o[0] && !f111_vld_q) begin
        f111_idx_d = idx_q;
        f111_vld_d = 1'b1;
      end
      if (det_o[1] && !f001_vld_q) begin
        f001_idx_d = idx_q;
        f001_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      f111_idx_q <= '0;
      f001_idx_q <= '0;
      f111_vld_q <= 1'b0;
      f001_vld_q <= 1'b0;
    end else begin
      f111_idx_q <= f111_idx_d;
      f001_idx_q <= f001_idx_d;
      f111_vld_q <= f111_vld_d;
      f001_vld_q <= f001_vld_d;
    end
  end

  assign first_111_idx = f111_idx_q;
  assign first_001_idx = f001_idx_q;
  assign first_111_vld = f111_vld_q;
  assign first_001_vld = f001_vld_q;
`endif

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    len_d     = len_q;
    idx_d     = idx_q;
    cnt_111_d = cnt_111_q;
    cnt_001_d = cnt_001_q;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    det_i     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) begin
          shreg_d   = word;
          len_d     = len_clamp;
          idx_d     = '0;
          cnt_111_d = '0;
          cnt_001_d = '0;
          state_d   = (len_clamp == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        busy  = 1'b1;
        det_i = shreg_q[0];
        if (count_en) begin
          if (det_o[0] && (cnt_111_q != {CNT_W{1'b1}})) cnt_111_d = cnt_111_q + CNT_W'(1);
          if (det_o[1] && (cnt_001_q != {CNT_W{1'b1}})) cnt_001_d = cnt_001_q + CNT_W'(1);
        end
        shreg_d = shreg_q >> 1;
        idx_d   = idx_q + LEN_W'(1);
        if (idx_q == len_q - LEN_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      cnt_111_q <= '0;
      cnt_001_q <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      cnt_111_q <= cnt_111_d;
      cnt_001_q <= cnt_001_d;
    end
  end

  assign cnt_111 = cnt_111_q;
  assign cnt_001 = cnt_001_q;

endmodule

// File: tb/tb_mealy_pattern_sequencer.sv
// Bench for mealy_pattern_sequencer: table of streamed words plus hand-written start-hold and reset sequences.
// A behavioural 3-bit Mealy detector (no reset) closes the loop for an 8-bit and a 3-bit counter instance.
module tb_mealy_pattern_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] word;
  logic [4:0]  len;
  logic        ready, busy, done, det_i;
  logic [1:0]  det_o;
  logic [7:0]  cnt_111, cnt_001;
  logic        ready_s, busy_s, done_s, det_i_s;
  logic [1:0]  det_o_s;
  logic [2:0]  cnt_111_s, cnt_001_s;
  logic [1:0]  hist = 2'b11;
  logic [1:0]  hist_s = 2'b11;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  // Detector models: hist[1] is the older bit, det_i is the current bit.
  assign det_o   = {~hist[1] & ~hist[0] & det_i, hist[1] & hist[0] & det_i};
  assign det_o_s = {~hist_s[1] & ~hist_s[0] & det_i_s, hist_s[1] & hist_s[0] & det_i_s};
  always @(posedge clock) begin
    hist   <= {hist[0], det_i};
    hist_s <= {hist_s[0], det_i_s};
  end

`ifdef MEALY_SEQ_FIRSTHIT_EN
  logic [4:0] f111_idx, f001_idx, f111_idx_s, f001_idx_s;
  logic       f111_vld, f001_vld, f111_vld_s, f001_vld_s;
`endif

  mealy_pattern_sequencer #(.WORD_W(16), .LEN_W(5), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .start(start), .word(word), .len(len),
    .ready(ready), .busy(busy), .done(done), .det_i(det_i), .det_o(det_o),
    .cnt_111(cnt_111), .cnt_001(cnt_001)
`ifdef MEALY_SEQ_FIRSTHIT_EN
    , .first_111_idx(f111_idx), .first_001_idx(f001_idx),
    .first_111_vld(f111_vld), .first_001_vld(f001_vld)
`endif
  );

  mealy_pattern_sequencer #(.WORD_W(16), .LEN_W(5), .CNT_W(3)) dut_s (
    .clock(clock), .reset(reset), .start(start), .word(word), .len(len),
    .ready(ready_s), .busy(busy_s), .done(done_s), .det_i(det_i_s), .det_o(det_o_s),
    .cnt_111(cnt_111_s), .cnt_001(cnt_001_s)
`ifdef MEALY_SEQ_FIRSTHIT_EN
    , .first_111_idx(f111_idx_s), .first_001_idx(f001_idx_s),
    .first_111_vld(f111_vld_s), .first_001_vld(f001_vld_s)
`endif
  );

  typedef struct {
    logic [15:0] word;
    logic [4:0]  len;
    int          e111;
    int          e001;
    int          s111;
    int          s001;
    int          f111;
    int          f001;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input int n, input vec_t v);
    int eff_len, cyc, nrun, done_cyc, dones;
    bit finished;
    logic [15:0] w;
    w = v.word;
    eff_len = (v.len > 5'd16) ? 16 : int'(v.len);
    chk($sformatf("v%0d_ready_idle", n), 32'(ready), 1);
    chk($sformatf("v%0d_det_i_idle", n), 32'(det_i), 0);
    start = 1'b1;
    word  = v.word;
    len   = v.len;
    tick();
    start = 1'b0;
    word  = ~v.word;
    len   = 5'd3;
    nrun = 0; done_cyc = -1; dones = 0; finished = 0;
    for (cyc = 1; cyc <= 40; cyc++) begin
      if (ready) begin
        finished = 1;
        break;
      end
      if (busy) begin
        nrun++;
        if (cyc <= 16) chk($sformatf("v%0d_det_i_c%0d", n, cyc), 32'(det_i), 32'(w[cyc-1]));
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
        chk($sformatf("v%0d_det_i_done", n), 32'(det_i), 0);
      end
      tick();
    end
    chk($sformatf("v%0d_finished", n), 32'(finished), 1);
    chk($sformatf("v%0d_run_cycles", n), nrun, eff_len);
    chk($sformatf("v%0d_done_cycle", n), done_cyc, eff_len + 1);
    chk($sformatf("v%0d_done_pulses", n), dones, 1);
    chk($sformatf("v%0d_cnt_111", n), 32'(cnt_111), v.e111);
    chk($sformatf("v%0d_cnt_001", n), 32'(cnt_001), v.e001);
    chk($sformatf("v%0d_sat_cnt_111", n), 32'(cnt_111_s), v.s111);
    chk($sformatf("v%0d_sat_cnt_001", n), 32'(cnt_001_s), v.s001);
`ifdef MEALY_SEQ_FIRSTHIT_EN
    chk($sformatf("v%0d_f111_vld", n), 32'(f111_vld), 32'(v.f111 >= 0));
    chk($sformatf("v%0d_f001_vld", n), 32'(f001_vld), 32'(v.f001 >= 0));
    if (v.f111 >= 0) chk($sformatf("v%0d_f111_idx", n), 32'(f111_idx), v.f111);
    if (v.f001 >= 0) chk($sformatf("v%0d_f001_idx", n), 32'(f001_idx), v.f001);
`endif
  endtask

  initial begin
    int cyc, dones;
    bit got_ready;
    vecs[0] = '{16'hFF99, 5'd10, 1, 2, 1, 2, 9, 3};
    vecs[1] = '{16'hFFFF, 5'd16, 14, 0, 7, 0, 2, -1};
    vecs[2] = '{16'h0000, 5'd16, 0, 0, 0, 0, -1, -1};
    vecs[3] = '{16'h0001, 5'd1, 0, 0, 0, 0, -1, -1};
    vecs[4] = '{16'hFFFF, 5'd0, 0, 0, 0, 0, -1, -1};
    vecs[5] = '{16'hFFFF, 5'd20, 14, 0, 7, 0, 2, -1};
    vecs[6] = '{16'h1249, 5'd16, 0, 4, 0, 4, -1, 3};
    vecs[7] = '{16'hFFFF, 5'd13, 11, 0, 7, 0, 2, -1};

    reset = 1'b1;
    start = 1'b0;
    word  = 16'h0;
    len   = 5'd0;
    tick();
    tick();
    chk("rst_ready", 32'(ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_det_i", 32'(det_i), 0);
    chk("rst_cnt_111", 32'(cnt_111), 0);
    chk("rst_cnt_001", 32'(cnt_001), 0);
    reset = 1'b0;
    tick();

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // start held high through the whole run: only cycle 12 may re-accept
    start = 1'b1;
    word  = 16'h0399;
    len   = 5'd10;
    tick();
    for (cyc = 1; cyc <= 11; cyc++) begin
      chk($sformatf("hold_not_ready_c%0d", cyc), 32'(ready), 0);
      if (cyc == 11) chk("hold_done_c11", 32'(done), 1);
      if (cyc < 11) tick();
    end
    tick();
    chk("hold_ready_c12", 32'(ready), 1);
    chk("hold_cnt_111", 32'(cnt_111), 1);
    chk("hold_cnt_001", 32'(cnt_001), 2);
    tick();
    start = 1'b0;
    chk("hold_reaccept_c13", 32'(busy), 1);
    got_ready = 0;
    for (cyc = 0; cyc < 40; cyc++) begin
      if (ready) begin
        got_ready = 1;
        break;
      end
      tick();
    end
    chk("hold_second_run_ends", 32'(got_ready), 1);
    chk("hold_second_cnt_111", 32'(cnt_111), 1);
    chk("hold_second_cnt_001", 32'(cnt_001), 2);

    // reset during RUN cycle 5
    start = 1'b1;
    word  = 16'hFFFF;
    len   = 5'd16;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    tick();
    chk("mid_busy_c5", 32'(busy), 1);
    chk("mid_cnt_111_c5", 32'(cnt_111), 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_ready", 32'(ready), 1);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_done", 32'(done), 0);
    chk("mid_cnt_111", 32'(cnt_111), 0);
    chk("mid_cnt_001", 32'(cnt_001), 0);
    chk("mid_sat_cnt_111", 32'(cnt_111_s), 0);
    dones = 0;
    for (cyc = 0; cyc < 20; cyc++) begin
      if (done || busy) dones++;
      tick();
    end
    chk("mid_no_done_after_reset", dones, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
